// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: defaults, packet layout, FSM encoding.
package spi_seq_pkg;

  localparam int unsigned DEF_NUM_SLAVES  = 8;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  // Command packet layout (LSB first): [0]=0, [1]=rw, [2]=mc, then addr, then id.
  localparam int unsigned PKT_RW_BIT   = 1;
  localparam int unsigned PKT_MC_BIT   = 2;
  localparam int unsigned PKT_ADDR_LSB = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_VSTART = 3'd4,
    S_VWAIT  = 3'd5,
    S_RESP   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-transfer watchdog: counts enabled cycles and flags when TIMEOUT_CYC is reached.
module seq_watchdog
  import spi_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Count while enabled; expired latches high once the limit is hit, until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      cnt     <= cnt + CNT_W'(1);
      expired <= (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Expands one read or multi-target write command into a series of SPI master transfers,
// with optional per-target read-back verify and a per-transfer watchdog.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned ID_W       = $clog2(NUM_SLAVES),
  localparam int unsigned CMD_W      = ID_W + ADDR_W + 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic                  cmd_verify,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [NUM_SLAVES-1:0] cmd_mask,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  master_start_tx,
  input  logic                  master_spi_busy,
  input  logic                  master_tx_done,
  output logic [CMD_W-1:0]      master_cmd_packet,
  output logic [DATA_W-1:0]     master_data_wr,
  input  logic [DATA_W-1:0]     master_data_rd,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [NUM_SLAVES-1:0] rsp_err_mask,
  output logic [NUM_SLAVES-1:0] rsp_tmo_mask,
  output logic                  seq_busy
);

  seq_state_t            state;
  logic                  reg_rw;
  logic                  reg_verify;
  logic                  reg_mc;
  logic [ADDR_W-1:0]     reg_addr;
  logic [DATA_W-1:0]     reg_wdata;
  logic [NUM_SLAVES-1:0] pend;
  logic [ID_W-1:0]       cur_id;
  logic                  pkt_loaded;
  logic                  wd_enable;
  logic                  wd_expired;

  // Build a command word from its fields; the top two bits stay zero.
  function automatic logic [CMD_W-1:0] make_pkt(input logic [ID_W-1:0] id,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic mc, input logic rw);
    logic [CMD_W-1:0] p;
    p = '0;
    p[PKT_RW_BIT] = rw;
    p[PKT_MC_BIT] = mc;
    p[PKT_ADDR_LSB +: ADDR_W] = addr;
    p[PKT_ADDR_LSB + ADDR_W +: ID_W] = id;
    return p;
  endfunction

  // Index of the lowest set bit (0 when none; callers check for empty first).
  function automatic logic [ID_W-1:0] lowest_id(input logic [NUM_SLAVES-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // True when more than one bit is set.
  function automatic logic multi_bit(input logic [NUM_SLAVES-1:0] v);
    return (v & (v - NUM_SLAVES'(1))) != '0;
  endfunction

  // Watchdog runs only while waiting on a transfer and restarts for every transfer.
  assign wd_enable = (state == S_WAIT) || (state == S_VWAIT);

  seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!wd_enable),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Sequencer FSM with registered outputs; the packet is loaded one cycle before the start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cmd_ready         <= 1'b0;
      seq_busy          <= 1'b0;
      master_start_tx   <= 1'b0;
      master_cmd_packet <= '0;
      master_data_wr    <= '0;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      rsp_err_mask      <= '0;
      rsp_tmo_mask      <= '0;
      reg_rw            <= 1'b0;
      reg_verify        <= 1'b0;
      reg_mc            <= 1'b0;
      reg_addr          <= '0;
      reg_wdata         <= '0;
      pend              <= '0;
      cur_id            <= '0;
      pkt_loaded        <= 1'b0;
    end else begin
      master_start_tx <= 1'b0;
      rsp_valid       <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            seq_busy     <= 1'b1;
            reg_rw       <= cmd_rw;
            reg_verify   <= cmd_verify & ~cmd_rw;
            reg_mc       <= ~cmd_rw & multi_bit(cmd_mask);
            reg_addr     <= cmd_addr;
            reg_wdata    <= cmd_wdata;
            pend         <= cmd_rw ? (NUM_SLAVES'(1) << cmd_id) : cmd_mask;
            rsp_rdata    <= '0;
            rsp_err_mask <= '0;
            rsp_tmo_mask <= '0;
            pkt_loaded   <= 1'b0;
            state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pend == '0) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cur_id               <= lowest_id(pend);
            pend[lowest_id(pend)] <= 1'b0;
            state                <= S_START;
          end
        end
        S_START: begin
          if (!pkt_loaded) begin
            master_cmd_packet <= make_pkt(cur_id, reg_addr, reg_mc, reg_rw);
            master_data_wr    <= reg_wdata;
            pkt_loaded        <= 1'b1;
          end else if (!master_spi_busy) begin
            master_start_tx <= 1'b1;
            pkt_loaded      <= 1'b0;
            state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (master_tx_done) begin
            if (reg_rw) begin
              rsp_rdata <= master_data_rd;
              state     <= S_SCAN;
            end else if (reg_verify) begin
              state <= S_VSTART;
            end else begin
              state <= S_SCAN;
            end
          end else if (wd_expired) begin
            rsp_tmo_mask[cur_id] <= 1'b1;
            state                <= S_SCAN;
          end
        end
        S_VSTART: begin
          if (!pkt_loaded) begin
            master_cmd_packet <= make_pkt(cur_id, reg_addr, 1'b0, 1'b1);
            pkt_loaded        <= 1'b1;
          end else if (!master_spi_busy) begin
            master_start_tx <= 1'b1;
            pkt_loaded      <= 1'b0;
            state           <= S_VWAIT;
          end
        end
        S_VWAIT: begin
          if (master_tx_done) begin
            if (master_data_rd != reg_wdata) rsp_err_mask[cur_id] <= 1'b1;
            state <= S_SCAN;
          end else if (wd_expired) begin
            rsp_tmo_mask[cur_id] <= 1'b1;
            state                <= S_SCAN;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          seq_busy  <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed plus randomized bench for spi_cmd_sequencer with a simple SPI slave model.
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;

  localparam int unsigned NS  = 8;
  localparam int unsigned IW  = 3;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 1024;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic          cmd_verify;
  logic [IW-1:0] cmd_id;
  logic [NS-1:0] cmd_mask;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          master_start_tx;
  logic          master_spi_busy;
  logic          master_tx_done;
  logic [CW-1:0] master_cmd_packet;
  logic [DW-1:0] master_data_wr;
  logic [DW-1:0] master_data_rd;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] rsp_err_mask;
  logic [NS-1:0] rsp_tmo_mask;
  logic          seq_busy;

  spi_cmd_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_rw            (cmd_rw),
    .cmd_verify        (cmd_verify),
    .cmd_id            (cmd_id),
    .cmd_mask          (cmd_mask),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .master_start_tx   (master_start_tx),
    .master_spi_busy   (master_spi_busy),
    .master_tx_done    (master_tx_done),
    .master_cmd_packet (master_cmd_packet),
    .master_data_wr    (master_data_wr),
    .master_data_rd    (master_data_rd),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err_mask      (rsp_err_mask),
    .rsp_tmo_mask      (rsp_tmo_mask),
    .seq_busy          (seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Slave-side state: read data per ID, an ID that never answers, observed transfers.
  logic [DW-1:0] slave_rd [NS];
  int            hang_id  = -1;
  int            spur_req = 0;
  int            spur_ack = 0;
  logic [CW-1:0] obs_pkt [$];
  logic [DW-1:0] obs_wr  [$];
  int            start_cyc = 0;
  int            done_cyc  = 0;

  // Reference expectations for the command in flight.
  logic [CW-1:0] exp_pkt [$];
  logic [DW-1:0] exp_wr  [$];
  bit            exp_chkwr [$];
  logic [DW-1:0] exp_rdata;
  logic [NS-1:0] exp_err;
  logic [NS-1:0] exp_tmo;
  int            acc_cyc = 0;
  int            rsp_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pkt_val(input int id, input int addr, input int mc, input int rw);
    return CW'(id * 2048 + addr * 8 + mc * 4 + rw * 2);
  endfunction

  // Expected transfers and response derived from the command and the slave contents.
  function automatic void model(input logic rw, input logic verify, input logic [IW-1:0] id,
                                input logic [NS-1:0] mask, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
    int n;
    exp_pkt.delete(); exp_wr.delete(); exp_chkwr.delete();
    exp_rdata = '0; exp_err = '0; exp_tmo = '0;
    if (rw) begin
      exp_pkt.push_back(pkt_val(int'(id), int'(addr), 0, 1));
      exp_wr.push_back('0); exp_chkwr.push_back(1'b0);
      if (int'(id) == hang_id) exp_tmo[id] = 1'b1;
      else exp_rdata = slave_rd[id];
    end else begin
      n = $countones(mask);
      for (int i = 0; i < int'(NS); i++) begin
        if (mask[i]) begin
          exp_pkt.push_back(pkt_val(i, int'(addr), (n > 1) ? 1 : 0, 0));
          exp_wr.push_back(wdata); exp_chkwr.push_back(1'b1);
          if (i == hang_id) begin
            exp_tmo[i] = 1'b1;
          end else if (verify) begin
            exp_pkt.push_back(pkt_val(i, int'(addr), 0, 1));
            exp_wr.push_back('0); exp_chkwr.push_back(1'b0);
            if (slave_rd[i] != wdata) exp_err[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Slave model: answers each start with busy, a random-latency done pulse and read data.
  initial begin
    logic [CW-1:0] p;
    int pid;
    int lat;
    int extra;
    master_spi_busy = 1'b0;
    master_tx_done  = 1'b0;
    master_data_rd  = '0;
    forever begin
      @(posedge clk); #1;
      if (master_start_tx) begin
        p = master_cmd_packet;
        obs_pkt.push_back(p);
        obs_wr.push_back(master_data_wr);
        start_cyc = cyc;
        pid = int'(p[13:11]);
        if (pid != hang_id) begin
          master_spi_busy = 1'b1;
          lat   = int'($urandom_range(4, 1));
          extra = int'($urandom_range(2, 0));
          repeat (lat) begin @(posedge clk); #1; end
          master_tx_done = 1'b1;
          master_data_rd = p[1] ? slave_rd[pid] : DW'($urandom);
          done_cyc = cyc;
          @(posedge clk); #1;
          master_tx_done = 1'b0;
          master_data_rd = DW'($urandom);
          repeat (extra) begin @(posedge clk); #1; end
          master_spi_busy = 1'b0;
        end
      end else if (spur_req != spur_ack) begin
        master_tx_done = 1'b1;
        master_data_rd = 16'hDEAD;
        @(posedge clk); #1;
        master_tx_done = 1'b0;
        spur_ack = spur_req;
      end
    end
  end

  // Issue one command, wait for its response and compare everything against the model.
  task automatic run_cmd(input logic rw, input logic verify, input logic [IW-1:0] id,
                         input logic [NS-1:0] mask, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit hold);
    int base;
    int w;
    int t;
    int bad_ready;
    int n_obs;
    base = obs_pkt.size();
    model(rw, verify, id, mask, addr, wdata);
    w = 0;
    while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_rw = rw; cmd_verify = verify; cmd_id = id;
    cmd_mask = mask; cmd_addr = addr; cmd_wdata = wdata;
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_verify = 1'($urandom); cmd_id = IW'($urandom);
    cmd_mask = NS'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    t = 0; bad_ready = 0;
    while (!rsp_valid && t < 3000) begin
      if (cmd_ready) bad_ready++;
      @(posedge clk); #1; t++;
    end
    rsp_cyc = cyc;
    cmd_valid = 1'b0;
    check("rsp_valid_seen", 64'(rsp_valid), 64'(1));
    check("ready_low_busy", 64'(bad_ready), 64'(0));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("rsp_err_mask", 64'(rsp_err_mask), 64'(exp_err));
    check("rsp_tmo_mask", 64'(rsp_tmo_mask), 64'(exp_tmo));
    n_obs = obs_pkt.size() - base;
    check("xfer_count", 64'(n_obs), 64'(exp_pkt.size()));
    for (int k = 0; k < exp_pkt.size() && k < n_obs; k++) begin
      check("packet", 64'(obs_pkt[base + k]), 64'(exp_pkt[k]));
      if (exp_chkwr[k]) check("data_wr", 64'(obs_wr[base + k]), 64'(exp_wr[k]));
    end
    @(posedge clk); #1;
    check("rsp_single_pulse", 64'(rsp_valid), 64'(0));
    check("rsp_hold", 64'({rsp_rdata, rsp_err_mask, rsp_tmo_mask}),
          64'({exp_rdata, exp_err, exp_tmo}));
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat_v;
    int seen;
    logic [DW-1:0] rd_before;
    logic [DW-1:0] wd;
    logic [NS-1:0] m;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_verify = 1'b0;
    cmd_id = '0; cmd_mask = '0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < int'(NS); i++) slave_rd[i] = '0;

    // Outputs during reset, then ready after release.
    repeat (3) @(posedge clk); #1;
    check("reset_ctrl", 64'({cmd_ready, master_start_tx, rsp_valid, seq_busy,
                             master_cmd_packet, master_data_wr}), 64'(0));
    check("reset_rsp", 64'({rsp_rdata, rsp_err_mask, rsp_tmo_mask}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'({cmd_ready, seq_busy}), 64'(2'b10));

    // Single read with latency checks.
    slave_rd[3] = 16'hBEEF;
    run_cmd(1'b1, 1'b1, 3'd3, 8'hFF, 8'h12, 16'h5555, 1'b0);
    check("read_rdata_beef", 64'(rsp_rdata), 64'(16'hBEEF));
    check("lat_accept_start", 64'(start_cyc - acc_cyc), 64'(4));
    check("lat_done_rsp", 64'(rsp_cyc - done_cyc), 64'(2));

    // Multicast write without verify.
    run_cmd(1'b0, 1'b0, 3'd0, 8'hA5, 8'h40, 16'h1234, 1'b0);

    // Single write with failing read-back.
    slave_rd[4] = 16'h1230;
    run_cmd(1'b0, 1'b1, 3'd0, 8'h10, 8'h33, 16'h1234, 1'b0);
    check("verify_err_mask", 64'(rsp_err_mask), 64'(8'h10));

    // Timeout on ID 1 while ID 2 is still written.
    hang_id = 1;
    run_cmd(1'b0, 1'b0, 3'd0, 8'h06, 8'h07, 16'hCAFE, 1'b0);
    check("tmo_mask", 64'(rsp_tmo_mask), 64'(8'h02));
    check("tmo_duration", 64'((rsp_cyc - acc_cyc) >= int'(TMO)), 64'(1));
    hang_id = -1;

    // Empty write mask, with cmd_valid held through the busy period.
    run_cmd(1'b0, 1'b1, 3'd0, 8'h00, 8'h01, 16'h0F0F, 1'b1);
    check("empty_mask_latency", 64'((rsp_cyc - acc_cyc) <= 3), 64'(1));
    run_cmd(1'b0, 1'b0, 3'd0, 8'h81, 8'h22, 16'h7777, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("held_valid_not_reissued", 64'(seq_busy), 64'(0));

    // Spurious done while idle is ignored.
    rd_before = rsp_rdata;
    seen = 0;
    spur_req++;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || seq_busy) seen++;
    end
    check("spurious_done_ignored", 64'(seen), 64'(0));
    check("spurious_rdata_kept", 64'(rsp_rdata), 64'(rd_before));

    // Reset while waiting on a transfer, then a clean command.
    hang_id = 5;
    while (!cmd_ready) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_id = 3'd5; cmd_addr = 8'h99;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("busy_before_reset", 64'(seq_busy), 64'(1));
    rst_n = 1'b0; #1;
    check("midreset_ctrl", 64'({cmd_ready, master_start_tx, rsp_valid, seq_busy,
                                master_cmd_packet, master_data_wr}), 64'(0));
    check("midreset_rsp", 64'({rsp_rdata, rsp_err_mask, rsp_tmo_mask}), 64'(0));
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    rst_n = 1'b1;
    hang_id = -1;
    repeat (5) begin @(posedge clk); #1; if (rsp_valid || seq_busy) seen++; end
    check("no_rsp_after_reset", 64'(seen), 64'(0));
    slave_rd[6] = 16'hA1B2;
    run_cmd(1'b1, 1'b0, 3'd6, 8'h00, 8'h5A, 16'h0000, 1'b0);

    // Randomized commands.
    for (int n = 0; n < 25; n++) begin
      wd = DW'($urandom);
      for (int i = 0; i < int'(NS); i++) slave_rd[i] = ($urandom_range(1, 0) == 1) ? wd : DW'($urandom);
      m = NS'($urandom);
      if ($urandom_range(7, 0) == 0) m = '0;
      run_cmd(1'($urandom), 1'($urandom), IW'($urandom), m, AW'($urandom), wd, 1'b0);
    end

    lat_v = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
